// File: rtl/stage_mem.sv
// MEM stage: issues one load/store at a time on the data bus, aligns and extends
// load data, and owns the MEM/WB result registers.
module stage_mem #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 EX_MEM_valid,
  input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0] EX_MEM_dataB,
  input  logic [2:0]           EX_MEM_funct3,
  input  logic                 EX_MEM_MemRead,
  input  logic                 EX_MEM_MemWrite,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  input  logic                 dmem_ready,
  output logic                 mem_stall,
  output logic                 MEM_WB_valid,
  output logic [REG_WIDTH-1:0] MEM_WB_alu_out,
  output logic [REG_WIDTH-1:0] MEM_WB_load_data,
  output logic                 misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   req_q, we_q, misal_q, wb_valid_q;
  logic [REG_WIDTH-1:0]   addr_q, wdata_q, result_q, wb_alu_q, wb_ld_q;
  logic [3:0]             be_q;
  logic [2:0]             f3_q;
  logic                   access, is_store, misal, start;

  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] off, input logic [2:0] f3,
                                          input logic store);
    if (!store)                store_be = 4'b1111;
    else if (f3[1:0] == 2'b00) store_be = 4'b0001 << off;
    else if (f3[1:0] == 2'b01) store_be = off[1] ? 4'b1100 : 4'b0011;
    else                       store_be = 4'b1111;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  // Lane is shifted down first, then sign/zero extended; 011/110/111 fall to LW.
  function automatic logic [31:0] align_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (f3)
      3'b000:  align_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  align_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  align_load = {24'd0, sh[7:0]};
      3'b101:  align_load = {16'd0, sh[15:0]};
      default: align_load = rd;
    endcase
  endfunction

  assign access   = EX_MEM_valid & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign is_store = EX_MEM_MemWrite;
  assign misal    = is_misaligned(EX_MEM_alu_out[1:0], EX_MEM_funct3);
  assign start    = (state_q == IDLE) && access && !misal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && !misal) state_d = BUSY;
      BUSY:    if (dmem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = start || (state_q == BUSY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      f3_q       <= 3'b000;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_ld_q    <= '0;
      misal_q    <= 1'b0;
    end else begin
      misal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            req_q      <= 1'b1;
            we_q       <= is_store;
            addr_q     <= EX_MEM_alu_out;
            wdata_q    <= store_wdata(EX_MEM_dataB, EX_MEM_funct3);
            be_q       <= store_be(EX_MEM_alu_out[1:0], EX_MEM_funct3, is_store);
            f3_q       <= EX_MEM_funct3;
            wb_valid_q <= 1'b0;
          end else if (access) begin
            // misaligned access is squashed before it reaches the bus
            misal_q    <= 1'b1;
            wb_valid_q <= 1'b0;
          end else begin
            wb_valid_q <= EX_MEM_valid;
            wb_alu_q   <= EX_MEM_alu_out;
            wb_ld_q    <= '0;
          end
        end
        BUSY: begin
          wb_valid_q <= 1'b0;
          if (dmem_ready) begin
            req_q    <= 1'b0;
            result_q <= we_q ? '0 : align_load(dmem_rdata, addr_q[1:0], f3_q);
          end
        end
        DONE: begin
          wb_valid_q <= 1'b1;
          wb_alu_q   <= addr_q;
          wb_ld_q    <= result_q;
        end
        default: wb_valid_q <= 1'b0;
      endcase
    end
  end

  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = {addr_q[REG_WIDTH-1:2], 2'b00};
  assign dmem_wdata       = wdata_q;
  assign dmem_be          = be_q;
  assign MEM_WB_valid     = wb_valid_q;
  assign MEM_WB_alu_out   = wb_alu_q;
  assign MEM_WB_load_data = wb_ld_q;
  assign misaligned       = misal_q;

endmodule
